bool_mask_split: RTL

// - Boolean masking encoder: splits one unmasked K_WIDTH word into N_SHARES Boolean shares using fresh randomness.
// - XOR of all output shares equals the input word.
// - Sits at the front of the masked datapath and feeds the B2A / masked-XOR stages.
// - It is the inverse of the full-XOR share recombiner at the back end.
// - Pipelined: one randomness word is folded in per layer, with a register after each layer.

---
 rtl/masking_pkg.sv | 20 ++
 rtl/bool_mask_layer.sv | 48 ++++
 rtl/lix_reg.sv | 29 ++
 rtl/lix_xor.sv | 13 +
 rtl/bool_mask_split.sv | 81 ++++++++
 5 files changed

// File: rtl/masking_pkg.sv
// Shared helpers for the masked datapath: share indexing and
// pipeline-depth functions used by split, recombine and B2A blocks.
package masking_pkg;

  function automatic int unsigned f_layers(input int unsigned n);
    return n - 1;
  endfunction

  function automatic int unsigned f_randnum(input int unsigned n);
    return n - 1;
  endfunction

  function automatic int unsigned share_slice(
    input int unsigned i,
    input int unsigned k
  );
    return i * k;
  endfunction

endpackage

// File: rtl/bool_mask_layer.sv
// One masking layer J: folds r_J into share 0, deposits it as
// share J, passes the rest through, then registers the bus.
module bool_mask_layer
  import masking_pkg::*;
#(
  parameter  int K_WIDTH   = 32,
  parameter  int N_SHARES  = 3,
  parameter  int J         = 1,
  localparam int MASKWIDTH = K_WIDTH * N_SHARES
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en_i,
  input  logic [MASKWIDTH-1:0] s_i,
  input  logic [K_WIDTH-1:0]   r_i,
  output logic [MASKWIDTH-1:0] s_o
);

  logic [MASKWIDTH-1:0] s_d;

  // Share J is still all-zero on entry, so XOR-ing r_J
  // into it leaves exactly r_J.
  for (genvar i = 0; i < N_SHARES; i++) begin : g_sh
    if (i == 0 || i == J) begin : g_mix
      lix_xor #(
        .W(K_WIDTH)
      ) u_xor (
        .a_i(s_i[share_slice(i, K_WIDTH) +: K_WIDTH]),
        .b_i(r_i),
        .y_o(s_d[share_slice(i, K_WIDTH) +: K_WIDTH])
      );
    end else begin : g_pass
      assign s_d[share_slice(i, K_WIDTH) +: K_WIDTH] =
        s_i[share_slice(i, K_WIDTH) +: K_WIDTH];
    end
  end

  lix_reg #(
    .W(MASKWIDTH)
  ) u_sreg (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .en_i  (en_i),
    .d_i   (s_d),
    .q_o   (s_o)
  );

endmodule

// File: rtl/lix_reg.sv
// Leaf register cell: enable-gated D flop bank with async
// active-low clear.
module lix_reg #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  assign data_d = d_i;

  // Load on enable, hold otherwise, clear on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q <= '0;
    end else if (en_i) begin
      data_q <= data_d;
    end
  end

  assign q_o = data_q;

endmodule

// File: rtl/lix_xor.sv
// Leaf XOR cell: bitwise XOR of two equal-width words,
// no carries between bits.
module lix_xor #(
  parameter int W = 1
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] y_o
);

  assign y_o = a_i ^ b_i;

endmodule

// File: rtl/bool_mask_split.sv
// Boolean masking encoder: splits one word into N_SHARES shares,
// one fresh random word folded in per pipeline layer.
module bool_mask_split
  import masking_pkg::*;
#(
  parameter  int K_WIDTH   = 32,
  parameter  int N_SHARES  = 3,
  localparam int MASKWIDTH = K_WIDTH * N_SHARES,
  localparam int LAYERS    = int'(f_layers(N_SHARES)),
  localparam int RANDNUM   = int'(f_randnum(N_SHARES))
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         i_dvld,
  input  logic                         i_rvld,
  input  logic [K_WIDTH-1:0]           i_x,
  input  logic [K_WIDTH*RANDNUM-1:0]   i_n,
  output logic [MASKWIDTH-1:0]         o_z,
  output logic                         o_dvld
);

  logic [LAYERS:0]      v;
  logic [LAYERS-1:0]    en;
  logic [MASKWIDTH-1:0] sh [0:LAYERS];

  assign v[0]  = i_dvld;
  assign sh[0] = {{(MASKWIDTH-K_WIDTH){1'b0}}, i_x};

  // Valid chain advances on every enabled cycle; each data
  // layer loads only when the word entering it is valid.
  for (genvar j = 0; j < LAYERS; j++) begin : g_vld
    assign en[j] = v[j] & i_rvld;

    lix_reg #(
      .W(1)
    ) u_vreg (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .en_i  (i_rvld),
      .d_i   (v[j]),
      .q_o   (v[j+1])
    );
  end

  // Random word k rides k delay stages alongside its data
  // word, then is consumed by layer k+1.
  for (genvar k = 0; k < RANDNUM; k++) begin : g_layer
    logic [K_WIDTH-1:0] rd [0:k];

    assign rd[0] = i_n[k*K_WIDTH +: K_WIDTH];

    for (genvar m = 1; m <= k; m++) begin : g_rdly
      lix_reg #(
        .W(K_WIDTH)
      ) u_rreg (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .en_i  (en[m-1]),
        .d_i   (rd[m-1]),
        .q_o   (rd[m])
      );
    end

    bool_mask_layer #(
      .K_WIDTH (K_WIDTH),
      .N_SHARES(N_SHARES),
      .J       (k + 1)
    ) u_layer (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .en_i  (en[k]),
      .s_i   (sh[k]),
      .r_i   (rd[k]),
      .s_o   (sh[k+1])
    );
  end

  assign o_z    = sh[LAYERS];
  assign o_dvld = v[LAYERS];

endmodule
